// File: rtl/bus_pkg.sv
// Shared data-bus types for responders and interconnect.
// Provides responder FSM states, the full-word mask and the request bundle.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } resp_state_t;

  localparam logic [3:0] BUS_WMASK_WORD = 4'b1111;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        ren;
    logic        wen;
  } bus_req_t;

endpackage

// File: rtl/bram_be.sv
// Single-port 32-bit RAM with byte-lane write enables and registered read.
// Ports: clk, en (access strobe), we (lane enables), addr, wdata, rdata.
module bram_be #(
  parameter int DEPTH  = 4096,
  parameter int AW     = $clog2(DEPTH),
  parameter     INIT_H = ""
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  (* ram_style = "block" *)
  logic [31:0] mem [DEPTH];

  // rdata only moves on an access, so it holds between accesses
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bus_ram_responder.sv
// Data-bus responder: decodes an address window onto block RAM with wait states.
// Ports: clk, rst (sync, active low), bus_* request/response, access_err pulse.
module bus_ram_responder
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          DEPTH_W     = 4096,
  parameter int          WAIT_STATES = 1,
  parameter              INIT_H      = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wmask,
  input  logic        bus_ren,
  input  logic        bus_wen,
  output logic [31:0] bus_rdata,
  output logic        bus_done,
  output logic        access_err
);

  localparam int          AW    = $clog2(DEPTH_W);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_W);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  resp_state_t state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        accept, exec;

  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wmask_q;
  logic          wr_q;
  logic          win_q;
  logic          rd_ok;
  logic          err_q;

  logic          req;
  logic          in_win;
  logic [31:0]   offs;
  logic [AW-1:0] idx;

  logic          ram_en;
  logic [3:0]    ram_we;
  logic [31:0]   ram_q;

  assign req    = bus_ren | bus_wen;
  assign offs   = bus_addr - BASE_ADDR;
  assign idx    = AW'(offs >> 2);
  assign in_win = (bus_addr >= BASE_ADDR) &&
                  ({1'b0, bus_addr} < LIMIT);

  // cnt counts the remaining stall cycles; the access itself
  // happens on the edge where it reads zero, so a synchronous
  // read still costs one stall cycle with no wait states
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    exec     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (req) begin
          accept   = 1'b1;
          state_nx = WAIT;
          cnt_nx   = WS;
        end else begin
          state_nx = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          exec     = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      rd_ok <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err_q <= exec & ~win_q;
      if (exec) rd_ok <= ~wr_q & win_q;
    end
  end

  // both ren and wen high is a write
  always_ff @(posedge clk) begin
    if (rst && accept) begin
      idx_q   <= idx;
      wdata_q <= bus_wdata;
      wmask_q <= bus_wmask;
      wr_q    <= bus_wen;
      win_q   <= in_win;
    end
  end

  assign ram_en = exec & rst & win_q;
  assign ram_we = wr_q ? (wmask_q & BUS_WMASK_WORD) : 4'b0000;

  bram_be #(
    .DEPTH  (DEPTH_W),
    .AW     (AW),
    .INIT_H (INIT_H)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (ram_q)
  );

  assign bus_rdata  = rd_ok ? ram_q : 32'd0;
  assign bus_done   = (state != WAIT);
  assign access_err = err_q;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Scoreboard bench for bus_ram_responder with 2 and 0 wait states.
// Expected responses are queued at issue and popped at completion.
module tb_bus_ram_responder;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata;
  logic [3:0]  wmask;
  logic        ren, wen, sel;

  logic        ren0, wen0, ren1, wen1;
  logic [31:0] rd0, rd1;
  logic        done0, done1, err0, err1;
  logic [31:0] rd_m;
  logic        done_m, err_m;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  assign ren0   = ren & ~sel;
  assign wen0   = wen & ~sel;
  assign ren1   = ren & sel;
  assign wen1   = wen & sel;
  assign rd_m   = sel ? rd1 : rd0;
  assign done_m = sel ? done1 : done0;
  assign err_m  = sel ? err1 : err0;

  bus_ram_responder #(
    .BASE_ADDR   (32'h0001_0000),
    .DEPTH_W     (1024),
    .WAIT_STATES (2)
  ) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .bus_addr   (addr),
    .bus_wdata  (wdata),
    .bus_wmask  (wmask),
    .bus_ren    (ren0),
    .bus_wen    (wen0),
    .bus_rdata  (rd0),
    .bus_done   (done0),
    .access_err (err0)
  );

  bus_ram_responder #(
    .BASE_ADDR   (32'h0001_0000),
    .DEPTH_W     (1024),
    .WAIT_STATES (0)
  ) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .bus_addr   (addr),
    .bus_wdata  (wdata),
    .bus_wmask  (wmask),
    .bus_ren    (ren1),
    .bus_wen    (wen1),
    .bus_rdata  (rd1),
    .bus_done   (done1),
    .access_err (err1)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] xrd, input logic xerr);
    exp_t e;
    e.rd  = xrd;
    e.err = xerr;
    sb.push_back(e);
  endtask

  // count stall cycles at negedges until done rises (bounded)
  task automatic wait_done(output int low, output int errs);
    low  = 0;
    errs = 0;
    while (!done_m && low < 40) begin
      low++;
      if (err_m) errs++;
      @(negedge clk);
    end
    if (err_m) errs++;
  endtask

  task automatic txn(input bit s, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] m,
                     input logic r, input logic w,
                     input logic [31:0] xrd, input logic xerr,
                     input int xlow, input string tag);
    exp_t e;
    int   low, errs;
    push(xrd, xerr);
    @(negedge clk);
    sel = s; addr = a; wdata = wd; wmask = m; ren = r; wen = w;
    @(posedge clk);
    @(negedge clk);
    ren = 1'b0; wen = 1'b0;
    wait_done(low, errs);
    e = sb.pop_front();
    check({tag, "_low"}, 32'(low), 32'(xlow));
    check({tag, "_rd"}, rd_m, e.rd);
    check({tag, "_err"}, 32'(errs), {31'd0, e.err});
    @(negedge clk);
    check({tag, "_hold"}, rd_m, e.rd);
    check({tag, "_pulse"}, {31'd0, err_m}, 32'd0);
  endtask

  initial begin
    exp_t e;
    int   low, errs;
    rst = 1'b0; sel = 1'b0; addr = '0; wdata = '0;
    wmask = '0; ren = 1'b0; wen = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done0", {31'd0, done0}, 32'd1);
    check("rst_rd0", rd0, 32'd0);
    check("rst_err0", {31'd0, err0}, 32'd0);
    check("rst_done1", {31'd0, done1}, 32'd1);
    check("rst_rd1", rd1, 32'd0);
    rst = 1'b1;

    txn(0, 32'h0001_0010, 32'hDEADBEEF, 4'hF, 0, 1,
        32'h0, 0, 3, "wr10");
    txn(0, 32'h0001_0010, 32'h0, 4'h0, 1, 0,
        32'hDEADBEEF, 0, 3, "rd10");
    txn(0, 32'h0001_0020, 32'h11223344, 4'hF, 0, 1,
        32'h0, 0, 3, "wr20");
    txn(0, 32'h0001_0020, 32'h0000AA00, 4'b0010, 0, 1,
        32'h0, 0, 3, "wr20b");
    txn(0, 32'h0001_0020, 32'h0, 4'h0, 1, 0,
        32'h1122AA44, 0, 3, "rd20");
    txn(0, 32'h0002_0000, 32'h0, 4'h0, 1, 0,
        32'h0, 1, 3, "above");
    txn(0, 32'h0000_FFFC, 32'h0, 4'h0, 1, 0,
        32'h0, 1, 3, "below");
    txn(0, 32'h0001_0FFC, 32'hA5A5A5A5, 4'hF, 0, 1,
        32'h0, 0, 3, "wrtop");
    txn(0, 32'h0001_0FFC, 32'h0, 4'h0, 1, 0,
        32'hA5A5A5A5, 0, 3, "rdtop");
    txn(0, 32'h0001_1000, 32'h0, 4'h0, 1, 0,
        32'h0, 1, 3, "past");

    // request held during WAIT with a new address
    push(32'hDEADBEEF, 0);
    push(32'h1122AA44, 0);
    @(negedge clk);
    sel = 0; addr = 32'h0001_0010; ren = 1'b1;
    @(posedge clk);
    @(negedge clk);
    addr = 32'h0001_0020;
    wait_done(low, errs);
    e = sb.pop_front();
    check("hold1_low", 32'(low), 32'd3);
    check("hold1_rd", rd_m, e.rd);
    @(posedge clk);
    @(negedge clk);
    ren = 1'b0;
    wait_done(low, errs);
    e = sb.pop_front();
    check("hold2_low", 32'(low), 32'd3);
    check("hold2_rd", rd_m, e.rd);

    txn(0, 32'h0001_0040, 32'h00000055, 4'hF, 1, 1,
        32'h0, 0, 3, "rw");
    txn(0, 32'h0001_0040, 32'h0, 4'h0, 1, 0,
        32'h00000055, 0, 3, "rdrw");
    txn(0, 32'h0001_0010, 32'hFFFFFFFF, 4'h0, 0, 1,
        32'h0, 0, 3, "m0");
    txn(0, 32'h0001_0010, 32'h0, 4'h0, 1, 0,
        32'hDEADBEEF, 0, 3, "rdm0");

    // reset during WAIT discards the write
    txn(0, 32'h0001_0030, 32'hCAFEF00D, 4'hF, 0, 1,
        32'h0, 0, 3, "wr30");
    @(negedge clk);
    sel = 0; addr = 32'h0001_0030; wdata = 32'h12345678;
    wmask = 4'hF; wen = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wen = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("rstw_done", {31'd0, done0}, 32'd1);
    check("rstw_rd", rd0, 32'd0);
    rst = 1'b1;
    txn(0, 32'h0001_0030, 32'h0, 4'h0, 1, 0,
        32'hCAFEF00D, 0, 3, "rd30");

    // zero wait states
    txn(1, 32'h0001_0000, 32'hA0A0A0A0, 4'hF, 0, 1,
        32'h0, 0, 1, "z_wr0");
    txn(1, 32'h0001_0004, 32'h0B0B0B0B, 4'hF, 0, 1,
        32'h0, 0, 1, "z_wr4");
    push(32'hA0A0A0A0, 0);
    push(32'h0B0B0B0B, 0);
    @(negedge clk);
    sel = 1; addr = 32'h0001_0000; ren = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(low, errs);
    addr = 32'h0001_0004;
    e = sb.pop_front();
    check("b2b1_low", 32'(low), 32'd1);
    check("b2b1_rd", rd_m, e.rd);
    @(posedge clk);
    @(negedge clk);
    ren = 1'b0;
    wait_done(low, errs);
    e = sb.pop_front();
    check("b2b2_low", 32'(low), 32'd1);
    check("b2b2_rd", rd_m, e.rd);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
